// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive sequencer: mid-bit sampling, deframing, valid/ready delivery
// Define UART_RX_PARITY_EN to add a parity bit between data and stop.
module uart_rx_ctrl #(
  parameter int DATA_BITS     = 8,
  parameter int OVERSAMPLE    = 16,
  parameter int CLKS_PER_TICK = 27
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_sync,
`ifdef UART_RX_PARITY_EN
  input  logic                 parity_odd,
  output logic                 parity_err,
`endif
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int PW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_TICK - 1);
  localparam logic [TW-1:0] TCNT_HALF  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TCNT_FULL  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 deliver_q, deliver_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 tick;
  logic                 full_bit;
  logic                 transition;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d;
  logic                 par_err_q, par_err_d;
`endif

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    deliver_d   = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d   = par_bad_q;
    par_err_d   = 1'b0;
`endif
    tick     = (state_q != S_IDLE) && (presc_q == PRESC_LAST);
    full_bit = tick && (tcnt_q == TCNT_FULL);

    case (state_q)
      S_IDLE: begin
        if (!rx_sync) state_d = S_START;
      end
      S_START: begin
        if (tick && (tcnt_q == TCNT_HALF)) state_d = rx_sync ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (full_bit) begin
          shift_d   = {rx_sync, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (full_bit) begin
          par_bad_d = rx_sync ^ (^shift_q) ^ parity_odd;
          state_d   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (full_bit) begin
          if (rx_sync) begin
            deliver_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            par_err_d = par_bad_q;
`endif
            state_d   = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // Held-low line must return high before a new start edge is honoured.
        if (rx_sync) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    transition = (state_d != state_q);
    if (transition) bit_cnt_d = '0;

    if ((state_q == S_IDLE) || transition || tick) presc_d = '0;
    else                                            presc_d = presc_q + PW'(1);

    if (transition || full_bit) tcnt_d = '0;
    else if (tick)              tcnt_d = tcnt_q + TW'(1);
    else                        tcnt_d = tcnt_q;

    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q & ~rx_ready;
    overrun_d  = 1'b0;
    if (deliver_q) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      presc_q     <= '0;
      tcnt_q      <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      deliver_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q   <= 1'b0;
      par_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      tcnt_q      <= tcnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      deliver_q   <= deliver_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q   <= par_bad_d;
      par_err_q   <= par_err_d;
`endif
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_q;
  assign busy        = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err  = par_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed scoreboard bench for uart_rx_ctrl (8N1, 16x oversample, 4 clk/tick)
module tb_uart_rx_ctrl;
  localparam int BIT_CLKS = 64;
`ifdef UART_RX_PARITY_EN
  localparam int LATENCY = 674;
`else
  localparam int LATENCY = 610;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_sync = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun_err, busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_odd = 1'b0;
  logic       parity_err;
  int         n_pe = 0;
`endif

  int total = 0, bad = 0, cyc = 0;
  int n_acc = 0, n_fe = 0, n_ov = 0, n_vcyc = 0, rise_cyc = -1;
  int st, fe0, ov0, acc0, vc0;
  logic prev_valid = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] extra_bytes[3] = '{8'h00, 8'hFF, 8'h81};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_ctrl #(.DATA_BITS(8), .OVERSAMPLE(16), .CLKS_PER_TICK(4)) dut (
    .clk(clk),
    .rst(rst),
    .rx_sync(rx_sync),
`ifdef UART_RX_PARITY_EN
    .parity_odd(parity_odd),
    .parity_err(parity_err),
`endif
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .frame_err(frame_err),
    .overrun_err(overrun_err),
    .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (rx_valid) n_vcyc++;
      if (rx_valid && !prev_valid) rise_cyc = cyc;
      prev_valid = rx_valid;
      if (frame_err) n_fe++;
      if (overrun_err) n_ov++;
`ifdef UART_RX_PARITY_EN
      if (parity_err) n_pe++;
`endif
      if (frame_err || overrun_err) check("err_exclusive", {31'b0, frame_err & overrun_err}, 32'd0);
      if (rx_valid && rx_ready) begin
        n_acc++;
        total++;
        assert (exp_q.size() > 0) else begin
          bad++;
          $error("FAIL unexpected_word: observed=%0h expected=none", rx_data);
        end
        if (exp_q.size() > 0) check("rx_data_scoreboard", {24'b0, rx_data}, {24'b0, exp_q.pop_front()});
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bits(input logic [15:0] pat, input int n);
    for (int i = 0; i < n; i++) begin
      rx_sync = pat[i];
      wait_clks(BIT_CLKS);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    logic [15:0] pat;
`ifdef UART_RX_PARITY_EN
    pat = {5'b0, stop, (^d) ^ parity_odd, d, 1'b0};
    drive_bits(pat, 11);
`else
    pat = {6'b0, stop, d, 1'b0};
    drive_bits(pat, 10);
`endif
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] d, input logic par);
    logic [15:0] pat;
    pat = {5'b0, 1'b1, par, d, 1'b0};
    drive_bits(pat, 11);
  endtask
`endif

  initial begin
    wait_clks(3);
    check("reset_rx_data", {24'b0, rx_data}, 32'd0);
    check("reset_rx_valid", {31'b0, rx_valid}, 32'd0);
    check("reset_frame_err", {31'b0, frame_err}, 32'd0);
    check("reset_overrun", {31'b0, overrun_err}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;
    wait_clks(5);

    // Clean frame, consumer ready
    fe0 = n_fe; ov0 = n_ov; vc0 = n_vcyc;
    exp_q.push_back(8'hA5);
    st = cyc;
    send_frame(8'hA5, 1'b1);
    wait_clks(20);
    check("t1_accepts", n_acc, 32'd1);
    check("t1_valid_cycles", n_vcyc - vc0, 32'd1);
    check("t1_latency", rise_cyc - st, LATENCY);
    check("t1_no_frame_err", n_fe - fe0, 32'd0);
    check("t1_no_overrun", n_ov - ov0, 32'd0);

    foreach (extra_bytes[i]) begin
      exp_q.push_back(extra_bytes[i]);
      send_frame(extra_bytes[i], 1'b1);
      wait_clks(10);
    end
    check("extra_accepts", n_acc, 32'd4);

    // Short glitch rejected at mid start bit
    fe0 = n_fe; vc0 = n_vcyc;
    rx_sync = 1'b0;
    wait_clks(5);
    check("t2_busy_during_glitch", {31'b0, busy}, 32'd1);
    wait_clks(15);
    rx_sync = 1'b1;
    wait_clks(40);
    check("t2_idle_after_glitch", {31'b0, busy}, 32'd0);
    check("t2_no_valid", n_vcyc - vc0, 32'd0);
    check("t2_no_frame_err", n_fe - fe0, 32'd0);

    // Bad stop bit with line held low
    fe0 = n_fe; acc0 = n_acc; vc0 = n_vcyc;
    send_frame(8'h3C, 1'b0);
    wait_clks(200);
    check("t3_busy_while_low", {31'b0, busy}, 32'd1);
    check("t3_one_frame_err", n_fe - fe0, 32'd1);
    check("t3_no_valid", n_vcyc - vc0, 32'd0);
    rx_sync = 1'b1;
    wait_clks(2);
    check("t3_idle_after_high", {31'b0, busy}, 32'd0);
    wait_clks(100);
    check("t3_no_restart", {31'b0, busy}, 32'd0);
    check("t3_no_accept", n_acc - acc0, 32'd0);

    // Overrun: second word arrives while first is unaccepted
    rx_ready = 1'b0;
    ov0 = n_ov;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    wait_clks(10);
    check("t4_valid_held", {31'b0, rx_valid}, 32'd1);
    check("t4_first_word", {24'b0, rx_data}, 32'h11);
    send_frame(8'h22, 1'b1);
    wait_clks(10);
    check("t4_one_overrun", n_ov - ov0, 32'd1);
    check("t4_old_word_kept", {24'b0, rx_data}, 32'h11);
    check("t4_valid_still", {31'b0, rx_valid}, 32'd1);
    rx_ready = 1'b1;
    wait_clks(1);
    check("t4_valid_falls", {31'b0, rx_valid}, 32'd0);
    check("t4_scoreboard_drained", exp_q.size(), 32'd0);

    // Reset in the middle of data bit 4 of an abandoned frame
    fe0 = n_fe; acc0 = n_acc;
    drive_bits(16'h01E0, 5);
    rx_sync = 1'b1;
    wait_clks(32);
    rst = 1'b1;
    wait_clks(1);
    rst = 1'b0;
    check("t5_rx_data_cleared", {24'b0, rx_data}, 32'd0);
    check("t5_rx_valid_cleared", {31'b0, rx_valid}, 32'd0);
    check("t5_frame_err_clear", {31'b0, frame_err}, 32'd0);
    check("t5_overrun_clear", {31'b0, overrun_err}, 32'd0);
    check("t5_busy_clear", {31'b0, busy}, 32'd0);
    wait_clks(200);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    wait_clks(10);
    check("t5_clean_accept", n_acc - acc0, 32'd1);
    check("t5_no_frame_err", n_fe - fe0, 32'd0);

`ifdef UART_RX_PARITY_EN
    begin
      int pe0;
      parity_odd = 1'b0;
      pe0 = n_pe;
      exp_q.push_back(8'h07);
      send_frame_par(8'h07, 1'b1);
      wait_clks(10);
      check("t6_good_parity", n_pe - pe0, 32'd0);
      exp_q.push_back(8'h07);
      send_frame_par(8'h07, 1'b0);
      wait_clks(10);
      check("t6_bad_parity_pulse", n_pe - pe0, 32'd1);
      check("t6_word_delivered", {24'b0, rx_data}, 32'h07);
    end
`endif

    check("final_scoreboard_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
